// File: rtl/hcu_pkg.sv
// -----------------------------------------------------------------------------
// hcu_pkg
// Shared types and decode helpers for the hazard control unit.
//   - hcu_state_e : front-end control state (RUN / FLUSH)
//   - opcode group constants for jumps and flag-conditional branches
//   - is_taken()  : decides whether the ID instruction transfers control
// -----------------------------------------------------------------------------
package hcu_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hcu_state_e;

  // Unconditional transfers: one exact opcode plus a four-opcode group.
  localparam logic [5:0] JMP_OPC = 6'b111100;
  localparam logic [3:0] JMP_GRP = 4'b1110;

  // Conditional branches: opcode[5:3] selects the group, opcode[2:1] the flag test.
  localparam logic [2:0] BR_GRP  = 3'b101;
  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_NC = 2'b11;

  // Returns 1 when the opcode in ID redirects the PC given the current flags.
  function automatic logic is_taken(input logic [5:0] opcode,
                                    input logic       zero,
                                    input logic       carry);
    logic taken;
    taken = 1'b0;
    if ((opcode == JMP_OPC) || (opcode[5:2] == JMP_GRP)) begin
      taken = 1'b1;
    end else if (opcode[5:3] == BR_GRP) begin
      case (opcode[2:1])
        COND_Z:  taken = zero;
        COND_NZ: taken = ~zero;
        COND_C:  taken = carry;
        COND_NC: taken = ~carry;
        default: taken = 1'b0;
      endcase
    end else begin
      taken = 1'b0;
    end
    return taken;
  endfunction

endpackage

// File: rtl/hcu_sat_counter.sv
// -----------------------------------------------------------------------------
// hcu_sat_counter
// Saturating up-counter for performance statistics. Sticks at all-ones;
// clear wins over increment in the same cycle.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear
//   cnt        : current count
// -----------------------------------------------------------------------------
module hcu_sat_counter
  import hcu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline hazard controller beside the ID stage. Stalls on load-use hazards,
// flushes wrong-path fetches for BR_PENALTY cycles after a taken jump/branch
// decided in ID, and freezes the front end while memory is busy.
// Ports:
//   mem_busy                  : freeze front end (all controls low, state holds)
//   ex_mem_read, ex_rd        : load in EX and its destination
//   id_rs/id_rt, id_uses_*    : ID source registers and whether they are read
//   id_opcode, zero, carry    : transfer decode inputs
//   cnt_clr                   : synchronous clear of both counters
//   ld_pc, ld_if_id           : load enables (combinational)
//   if_id_flush, id_ex_flush  : bubble inserts (combinational)
//   br_taken                  : taken transfer decided this cycle
//   stall_cnt, flush_cnt      : saturating load-use stall / IF-ID flush counts
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hcu_pkg::*;
#(
  parameter int REG_AW         = 3,
  parameter int BR_PENALTY     = 1,
  parameter bit REG0_HARDWIRED = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_busy,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [5:0]        id_opcode,
  input  logic              zero,
  input  logic              carry,
  input  logic              cnt_clr,
  output logic              ld_pc,
  output logic              ld_if_id,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              br_taken,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Remaining flush cycles loaded on a taken transfer (the taken cycle itself
  // is the first flush cycle).
  localparam logic [2:0] REM_INIT = 3'(BR_PENALTY - 1);

  hcu_state_e state_q;
  hcu_state_e state_d;
  logic [2:0] rem_q;
  logic [2:0] rem_d;

  logic lu_s;
  logic taken_s;
  logic rd_nonzero_s;
  logic ld_pc_s;
  logic ld_if_id_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;
  logic br_taken_s;
  logic stall_inc_s;
  logic flush_inc_s;

  // Load-use detection; register 0 is ignored when it is hardwired.
  always_comb begin
    rd_nonzero_s = (REG0_HARDWIRED == 1'b0) || (ex_rd != {REG_AW{1'b0}});
    lu_s = ex_mem_read && rd_nonzero_s &&
           ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
    taken_s = is_taken(id_opcode, zero, carry);
  end

  // Next-state and control outputs; priority reset > mem_busy > lu > taken.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    ld_pc_s       = 1'b0;
    ld_if_id_s    = 1'b0;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    br_taken_s    = 1'b0;
    stall_inc_s   = 1'b0;
    flush_inc_s   = 1'b0;
    if (!rst_n) begin
      // Controls are forced low for the whole time reset is asserted.
      state_d = RUN;
      rem_d   = 3'd0;
    end else if (mem_busy) begin
      // Front end frozen: everything holds.
      state_d = state_q;
      rem_d   = rem_q;
    end else begin
      case (state_q)
        RUN: begin
          if (lu_s) begin
            // Hold PC and IF-ID, bubble into ID-EX; any transfer in ID is
            // decoded again next cycle once the hazard is gone.
            id_ex_flush_s = 1'b1;
            stall_inc_s   = 1'b1;
          end else if (taken_s) begin
            br_taken_s    = 1'b1;
            ld_pc_s       = 1'b1;
            ld_if_id_s    = 1'b1;
            if_id_flush_s = 1'b1;
            flush_inc_s   = 1'b1;
            if (BR_PENALTY > 1) begin
              state_d = FLUSH;
              rem_d   = REM_INIT;
            end else begin
              state_d = RUN;
              rem_d   = 3'd0;
            end
          end else begin
            ld_pc_s    = 1'b1;
            ld_if_id_s = 1'b1;
          end
        end
        FLUSH: begin
          // ID holds a squashed fetch, so hazards and transfers are ignored.
          ld_pc_s       = 1'b1;
          ld_if_id_s    = 1'b1;
          if_id_flush_s = 1'b1;
          flush_inc_s   = 1'b1;
          if (rem_q <= 3'd1) begin
            state_d = RUN;
            rem_d   = 3'd0;
          end else begin
            state_d = FLUSH;
            rem_d   = rem_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
  end

  // FSM state and remaining-flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign ld_pc       = ld_pc_s;
  assign ld_if_id    = ld_if_id_s;
  assign if_id_flush = if_id_flush_s;
  assign id_ex_flush = id_ex_flush_s;
  assign br_taken    = br_taken_s;

  hcu_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  hcu_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int REG_AW     = 3;
  localparam int BR_PENALTY = 3;
  localparam int CNT_W      = 2;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n, mem_busy, ex_mem_read, id_uses_rs, id_uses_rt, zero, carry, cnt_clr;
  logic [REG_AW-1:0] ex_rd, id_rs, id_rt;
  logic [5:0] id_opcode;
  logic ld_pc, ld_if_id, if_id_flush, id_ex_flush, br_taken;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_control_unit #(
    .REG_AW(REG_AW), .BR_PENALTY(BR_PENALTY), .REG0_HARDWIRED(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_opcode(id_opcode), .zero(zero), .carry(carry),
    .cnt_clr(cnt_clr), .ld_pc(ld_pc), .ld_if_id(ld_if_id), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .br_taken(br_taken), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ld_pc, ld_if_id, if_id_flush, id_ex_flush, br_taken, stall, flush;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: flush cycles still owed, counter values.
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic bit ref_taken(int opc, bit z, bit c);
    int cc;
    if (opc == 60 || (opc / 4) == 14) return 1'b1;
    if ((opc / 8) == 5) begin
      cc = (opc / 2) % 4;
      if (cc == 0) return z;
      if (cc == 1) return !z;
      if (cc == 2) return c;
      return !c;
    end
    return 1'b0;
  endfunction

  // Compute expectation for the current inputs, push it, advance one clock.
  task automatic tick();
    exp_t e;
    bit lu;
    e.cyc = cyc;
    e.ld_pc = 0; e.ld_if_id = 0; e.if_id_flush = 0; e.id_ex_flush = 0; e.br_taken = 0;
    if (!rst_n) begin
      m_left = 0; m_stall = 0; m_flush = 0;
      e.stall = 0; e.flush = 0;
    end else begin
      e.stall = m_stall;
      e.flush = m_flush;
      lu = ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
      if (mem_busy) begin
        // nothing moves
      end else if (m_left > 0) begin
        e.ld_pc = 1; e.ld_if_id = 1; e.if_id_flush = 1;
        m_left--; m_flush++;
      end else if (lu) begin
        e.id_ex_flush = 1;
        m_stall++;
      end else if (ref_taken(int'(id_opcode), zero, carry)) begin
        e.br_taken = 1; e.ld_pc = 1; e.ld_if_id = 1; e.if_id_flush = 1;
        m_left = BR_PENALTY - 1; m_flush++;
      end else begin
        e.ld_pc = 1; e.ld_if_id = 1;
      end
      if (m_stall > CMAX) m_stall = CMAX;
      if (m_flush > CMAX) m_flush = CMAX;
      if (cnt_clr) begin m_stall = 0; m_flush = 0; end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string name, int c, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // Monitor: controls are combinational and valid every cycle; sample mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ld_pc",       e.cyc, int'(ld_pc),       e.ld_pc);
      chk("ld_if_id",    e.cyc, int'(ld_if_id),    e.ld_if_id);
      chk("if_id_flush", e.cyc, int'(if_id_flush), e.if_id_flush);
      chk("id_ex_flush", e.cyc, int'(id_ex_flush), e.id_ex_flush);
      chk("br_taken",    e.cyc, int'(br_taken),    e.br_taken);
      chk("stall_cnt",   e.cyc, int'(stall_cnt),   e.stall);
      chk("flush_cnt",   e.cyc, int'(flush_cnt),   e.flush);
    end
  end

  task automatic idle();
    rst_n = 1'b1; mem_busy = 1'b0; ex_mem_read = 1'b0; ex_rd = 3'd0;
    id_rs = 3'd1; id_rt = 3'd2; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_opcode = 6'b000000; zero = 1'b0; carry = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load_use(input logic [5:0] opc);
    idle(); ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    id_opcode = opc;
  endtask

  task automatic rand_inputs();
    int k;
    rst_n       = ($urandom_range(0, 199) != 0);
    mem_busy    = ($urandom_range(0, 5) == 0);
    cnt_clr     = ($urandom_range(0, 15) == 0);
    ex_mem_read = $urandom_range(0, 1);
    ex_rd       = REG_AW'($urandom_range(0, 7));
    id_rs       = ($urandom_range(0, 2) == 0) ? ex_rd : REG_AW'($urandom_range(0, 7));
    id_rt       = ($urandom_range(0, 2) == 0) ? ex_rd : REG_AW'($urandom_range(0, 7));
    id_uses_rs  = $urandom_range(0, 1);
    id_uses_rt  = $urandom_range(0, 1);
    zero        = $urandom_range(0, 1);
    carry       = $urandom_range(0, 1);
    k = $urandom_range(0, 3);
    if (k == 0)      id_opcode = 6'($urandom_range(0, 63));
    else if (k == 1) id_opcode = 6'(40 + $urandom_range(0, 7));
    else if (k == 2) id_opcode = 6'(56 + $urandom_range(0, 3));
    else             id_opcode = 6'($urandom_range(0, 39));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    // Reset state with active-looking inputs.
    load_use(6'b111100); rst_n = 1'b0; tick();
    idle(); tick();
    // Load-use stall, then EX holds the bubble.
    load_use(6'b000000); tick();
    idle(); tick();
    // False dependencies.
    load_use(6'b000000); id_uses_rs = 1'b0; tick();
    idle(); ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs = 3'd0; id_uses_rs = 1'b1; tick();
    // Conditional branch on zero: taken, then two more flush cycles.
    idle(); id_opcode = 6'b101000; zero = 1'b1; tick();
    idle(); load_use(6'b111100); tick();  // suppressed in FLUSH
    idle(); id_opcode = 6'b101000; zero = 1'b1; tick();
    idle(); tick();
    idle(); id_opcode = 6'b101000; zero = 1'b0; tick();
    // Jump under load-use: stall first, then taken.
    load_use(6'b111100); tick();
    idle(); id_opcode = 6'b111100; tick();
    idle(); tick(); tick();
    // mem_busy in the middle of FLUSH.
    idle(); id_opcode = 6'b111000; tick();
    idle(); tick();
    idle(); mem_busy = 1'b1; tick(); tick();
    idle(); tick();
    idle(); tick();
    // Saturation: clear, then five stalls.
    idle(); cnt_clr = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin load_use(6'b000000); tick(); end
    idle(); tick();
    // Reset mid-FLUSH.
    idle(); id_opcode = 6'b101110; carry = 1'b0; tick();
    idle(); rst_n = 1'b0; tick();
    idle(); tick();
    idle(); id_opcode = 6'b111100; tick();
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end
    idle(); tick(); tick();
    @(negedge clk); #1;
    chk("scoreboard_drain", cyc, sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
